// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and operation classification for the
// registered MIPS execute-stage ALU.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_SHIFT,
    CLS_BRANCH,
    CLS_MULDIV,
    CLS_MOVE
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] opcode, input logic [5:0] funct);
    op_class_e cls;
    cls = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: cls = CLS_SHIFT;
          FN_MFHI, FN_MFLO:                                 cls = CLS_MOVE;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:               cls = CLS_MULDIV;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU:                  cls = CLS_ALU;
          default:                                          cls = CLS_NONE;
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: cls = CLS_ALU;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) on operand magnitudes,
// with sign fix-up applied to the final HI/LO outputs.
module mips_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  acc_q, sh_q, m_q, a_q;
  logic              div_q, neg_q, neg_r_q, div0_q;
  logic              a_neg, b_neg, last;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [2*WIDTH-1:0] step_out, prod;

  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0] sh,
                                              input logic [WIDTH-1:0] m,
                                              input logic             div);
    logic [WIDTH:0] sum, rem, diff;
    logic           ge;
    sum  = {1'b0, acc} + {1'b0, (sh[0] ? m : {WIDTH{1'b0}})};
    rem  = {acc, sh[WIDTH-1]};
    ge   = rem >= {1'b0, m};
    diff = rem - {1'b0, m};
    if (div) step = {(ge ? diff[WIDTH-1:0] : rem[WIDTH-1:0]), sh[WIDTH-2:0], ge};
    else     step = {sum[WIDTH:1], sum[0], sh[WIDTH-1:1]};
  endfunction

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign last  = (cnt_q == CNT_W'(WIDTH - 2));

  always_comb begin
    state_d = state_q;
    busy    = (state_q != MD_IDLE);
    done    = (state_q == MD_DONE);
    case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (last)  state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // The load edge already performs the first iteration, so the RUN state
  // needs only WIDTH-1 more and the result is ready WIDTH cycles after start.
  always_comb begin
    if (state_q == MD_IDLE)
      step_out = step('0, (is_div ? a_mag : b_mag), (is_div ? b_mag : a_mag), is_div);
    else
      step_out = step(acc_q, sh_q, m_q, div_q);
  end

  always_ff @(posedge clk) begin
    if (state_q == MD_IDLE && start) begin
      div_q          <= is_div;
      a_q            <= a;
      div0_q         <= (b == '0);
      neg_r_q        <= a_neg;
      neg_q          <= a_neg ^ b_neg;
      m_q            <= is_div ? b_mag : a_mag;
      {acc_q, sh_q}  <= step_out;
      cnt_q          <= '0;
    end else if (state_q == MD_RUN) begin
      {acc_q, sh_q}  <= step_out;
      cnt_q          <= cnt_q + 1'b1;
    end
  end

  assign prod = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};

  always_comb begin
    if (!div_q) begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end else if (div0_q) begin
      hi = a_q;
      lo = '1;
    end else begin
      hi = neg_r_q ? -acc_q : acc_q;
      lo = neg_q ? -sh_q : sh_q;
    end
  end

endmodule

// File: rtl/mips_alu_seq.sv
// Registered MIPS execute-stage ALU: single-cycle ops with 1-cycle latency,
// MULT/DIV through the iterative unit with architectural HI/LO.
module mips_alu_seq
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [IMM_W-1:0] immediate,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             overflow,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned EXT_W = WIDTH - IMM_W;
  localparam int unsigned MSB   = WIDTH - 1;

  op_class_e        cls;
  logic             accept, md_start, md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] imm_sx, imm_zx, sum_rr, diff_rr, sum_ri;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_branch, nxt_ovf;

  assign cls      = classify(opcode, funct);
  assign in_ready = !md_busy;
  assign accept   = in_valid && in_ready;
  assign md_start = accept && (cls == CLS_MULDIV);

  assign imm_sx  = {{EXT_W{immediate[IMM_W-1]}}, immediate};
  assign imm_zx  = {{EXT_W{1'b0}}, immediate};
  assign sum_rr  = rs_val + rt_val;
  assign diff_rr = rs_val - rt_val;
  assign sum_ri  = rs_val + imm_sx;

  mips_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .is_div    (funct == FN_DIV || funct == FN_DIVU),
    .is_signed (funct == FN_MULT || funct == FN_DIV),
    .a         (rs_val),
    .b         (rt_val),
    .busy      (md_busy),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_comb begin
    nxt_result = '0;
    nxt_branch = 1'b0;
    nxt_ovf    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            nxt_result = sum_rr;
            nxt_ovf    = (rs_val[MSB] == rt_val[MSB]) && (sum_rr[MSB] != rs_val[MSB]);
          end
          FN_SUB: begin
            nxt_result = diff_rr;
            nxt_ovf    = (rs_val[MSB] != rt_val[MSB]) && (diff_rr[MSB] != rs_val[MSB]);
          end
          FN_ADDU: nxt_result = sum_rr;
          FN_SUBU: nxt_result = diff_rr;
          FN_AND:  nxt_result = rs_val & rt_val;
          FN_OR:   nxt_result = rs_val | rt_val;
          FN_XOR:  nxt_result = rs_val ^ rt_val;
          FN_NOR:  nxt_result = ~(rs_val | rt_val);
          FN_SLT:  nxt_result[0] = $signed(rs_val) < $signed(rt_val);
          FN_SLTU: nxt_result[0] = rs_val < rt_val;
          FN_SLL:  nxt_result = rt_val << shamt;
          FN_SRL:  nxt_result = rt_val >> shamt;
          FN_SRA:  nxt_result = $signed(rt_val) >>> shamt;
          FN_SLLV: nxt_result = rt_val << rs_val[SH_W-1:0];
          FN_SRLV: nxt_result = rt_val >> rs_val[SH_W-1:0];
          FN_SRAV: nxt_result = $signed(rt_val) >>> rs_val[SH_W-1:0];
          FN_MFHI: nxt_result = hi_q;
          FN_MFLO: nxt_result = lo_q;
          default: nxt_result = '0;
        endcase
      end
      OP_ADDI: begin
        nxt_result = sum_ri;
        nxt_ovf    = (rs_val[MSB] == imm_sx[MSB]) && (sum_ri[MSB] != rs_val[MSB]);
      end
      OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: nxt_result = sum_ri;
      OP_SLTI:  nxt_result[0] = $signed(rs_val) < $signed(imm_sx);
      OP_SLTIU: nxt_result[0] = rs_val < imm_sx;
      OP_ANDI:  nxt_result = rs_val & imm_zx;
      OP_ORI:   nxt_result = rs_val | imm_zx;
      OP_XORI:  nxt_result = rs_val ^ imm_zx;
      OP_LUI:   nxt_result = {immediate, {EXT_W{1'b0}}};
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        nxt_result = imm_sx << 2;
        case (opcode)
          OP_BEQ:  nxt_branch = (rs_val == rt_val);
          OP_BNE:  nxt_branch = (rs_val != rt_val);
          OP_BLEZ: nxt_branch = rs_val[MSB] || (rs_val == '0);
          default: nxt_branch = !rs_val[MSB] && (rs_val != '0);
        endcase
      end
      default: nxt_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      overflow     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      out_valid <= 1'b0;
      if (md_done) begin
        out_valid    <= 1'b1;
        result       <= md_lo;
        branch_taken <= 1'b0;
        overflow     <= 1'b0;
        hi_q         <= md_hi;
        lo_q         <= md_lo;
      end else if (accept && cls != CLS_MULDIV) begin
        out_valid    <= 1'b1;
        result       <= nxt_result;
        branch_taken <= nxt_branch;
        overflow     <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Bench for mips_alu_seq: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mips_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [15:0] immediate = '0;
  logic        out_valid, branch_taken, overflow;
  logic [31:0] result, hi_q, lo_q;

  int total = 0;
  int bad = 0;

  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  always #5 clk = ~clk;

  mips_alu_seq #(.WIDTH(32), .IMM_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct        (funct),
    .shamt        (shamt),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .immediate    (immediate),
    .out_valid    (out_valid),
    .result       (result),
    .branch_taken (branch_taken),
    .overflow     (overflow),
    .hi_q         (hi_q),
    .lo_q         (lo_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour expressed as plain integer arithmetic.
  function automatic void model_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                                   input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output bit md, output logic [31:0] r, output bit br, output bit ov,
                                   output logic [31:0] nhi, output logic [31:0] nlo);
    longint sa_l, sb_l, ua, ub, sx_l, t, q, rm;
    logic [31:0] sx, zx;
    logic [63:0] pu;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    sx   = {{16{imm[15]}}, imm};
    zx   = {16'h0000, imm};
    sx_l = longint'($signed(sx));
    md = 0; r = '0; br = 0; ov = 0; nhi = hi; nlo = lo; t = 0;
    case (op)
      6'h00: case (fn)
        6'h20: begin t = sa_l + sb_l; r = t[31:0]; ov = (t > SMAX) || (t < SMIN); end
        6'h21: begin t = ua + ub; r = t[31:0]; end
        6'h22: begin t = sa_l - sb_l; r = t[31:0]; ov = (t > SMAX) || (t < SMIN); end
        6'h23: begin t = ua - ub; r = t[31:0]; end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (sa_l < sb_l) ? 32'd1 : 32'd0;
        6'h2B: r = (ua < ub) ? 32'd1 : 32'd0;
        6'h00: begin t = ub << sa; r = t[31:0]; end
        6'h02: begin t = ub >> sa; r = t[31:0]; end
        6'h03: begin t = sb_l >>> sa; r = t[31:0]; end
        6'h04: begin t = ub << a[4:0]; r = t[31:0]; end
        6'h06: begin t = ub >> a[4:0]; r = t[31:0]; end
        6'h07: begin t = sb_l >>> a[4:0]; r = t[31:0]; end
        6'h10: r = hi;
        6'h12: r = lo;
        6'h18: begin md = 1; t = sa_l * sb_l; nhi = t[63:32]; nlo = t[31:0]; end
        6'h19: begin md = 1; pu = {32'h0, a} * {32'h0, b}; nhi = pu[63:32]; nlo = pu[31:0]; end
        6'h1A, 6'h1B: begin
          md = 1;
          if (b == 32'h0) begin nlo = 32'hFFFFFFFF; nhi = a; end
          else if (fn == 6'h1A) begin q = sa_l / sb_l; rm = sa_l % sb_l; nlo = q[31:0]; nhi = rm[31:0]; end
          else begin q = ua / ub; rm = ua % ub; nlo = q[31:0]; nhi = rm[31:0]; end
        end
        default: r = '0;
      endcase
      6'h08: begin t = sa_l + sx_l; r = t[31:0]; ov = (t > SMAX) || (t < SMIN); end
      6'h09, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: r = a + sx;
      6'h0A: r = (sa_l < sx_l) ? 32'd1 : 32'd0;
      6'h0B: r = (a < sx) ? 32'd1 : 32'd0;
      6'h0C: r = a & zx;
      6'h0D: r = a | zx;
      6'h0E: r = a ^ zx;
      6'h0F: r = {imm, 16'h0000};
      6'h04: begin r = sx * 4; br = (a == b); end
      6'h05: begin r = sx * 4; br = (a != b); end
      6'h06: begin r = sx * 4; br = (sa_l <= 0); end
      6'h07: begin r = sx * 4; br = (sa_l > 0); end
      default: r = '0;
    endcase
  endfunction

  int          busy_cnt = 0;
  bit          exp_valid = 0, exp_br = 0, exp_ov = 0, chk_en = 0, m_rdy;
  logic [31:0] exp_result = '0, m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
  bit          c_md, c_br, c_ov;
  logic [31:0] c_r, c_nh, c_nl;

  always @(posedge clk) begin
    if (reset) begin
      busy_cnt = 0; exp_valid = 0; exp_br = 0; exp_ov = 0;
      exp_result = '0; m_hi = '0; m_lo = '0; chk_en = 1;
    end else begin
      m_rdy = (busy_cnt == 0);
      exp_valid = 0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          exp_valid = 1; exp_result = pend_lo; exp_br = 0; exp_ov = 0;
          m_hi = pend_hi; m_lo = pend_lo;
        end
      end
      if (in_valid && m_rdy) begin
        model_op(opcode, funct, shamt, rs_val, rt_val, immediate, m_hi, m_lo,
                 c_md, c_r, c_br, c_ov, c_nh, c_nl);
        if (c_md) begin
          busy_cnt = 32; pend_hi = c_nh; pend_lo = c_nl;
        end else begin
          exp_valid = 1; exp_result = c_r; exp_br = c_br; exp_ov = c_ov;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", in_ready, busy_cnt == 0);
      check("model_out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        check("model_result", result, exp_result);
        check("model_branch", branch_taken, exp_br);
        check("model_overflow", overflow, exp_ov);
      end
      check("model_hi", hi_q, m_hi);
      check("model_lo", lo_q, m_lo);
    end
  end

  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                      input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
    bit rdy, got;
    got = 0;
    opcode = op; funct = fn; shamt = sa; rs_val = a; rt_val = b; immediate = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin got = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 60 cycles");
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input logic br, input logic ov);
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) break;
      @(negedge clk);
    end
    check({name, "_valid"}, out_valid, 1);
    check(name, result, r);
    check({name, "_br"}, branch_taken, br);
    check({name, "_ov"}, overflow, ov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bit stall_ok;
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_branch", branch_taken, 0);
    check("rst_overflow", overflow, 0);
    check("rst_hi", hi_q, 0);
    check("rst_lo", lo_q, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send(6'h00, 6'h20, 0, 32'h7FFFFFFF, 32'h1, 0);  expect_out("add_ovf", 32'h80000000, 0, 1);
    send(6'h00, 6'h21, 0, 32'h7FFFFFFF, 32'h1, 0);  expect_out("addu", 32'h80000000, 0, 0);
    send(6'h00, 6'h22, 0, 32'h80000000, 32'h1, 0);  expect_out("sub_ovf", 32'h7FFFFFFF, 0, 1);
    send(6'h00, 6'h2A, 0, 32'hFFFFFFFF, 32'h1, 0);  expect_out("slt", 32'h1, 0, 0);
    send(6'h00, 6'h2B, 0, 32'hFFFFFFFF, 32'h1, 0);  expect_out("sltu", 32'h0, 0, 0);
    send(6'h00, 6'h03, 4, 32'h0, 32'h80000000, 0);  expect_out("sra", 32'hF8000000, 0, 0);
    send(6'h00, 6'h07, 0, 32'd36, 32'h80000000, 0); expect_out("srav", 32'hF8000000, 0, 0);
    send(6'h00, 6'h27, 0, 32'h0F0F0000, 32'h000000FF, 0); expect_out("nor", 32'hF0F0FF00, 0, 0);
    send(6'h0B, 6'h00, 0, 32'd5, 32'h0, 16'hFFFF);  expect_out("sltiu", 32'h1, 0, 0);
    send(6'h0C, 6'h00, 0, 32'hFFFFFFFF, 32'h0, 16'h8000); expect_out("andi", 32'h00008000, 0, 0);
    send(6'h0F, 6'h00, 0, 32'hDEADBEEF, 32'h0, 16'h1234); expect_out("lui", 32'h12340000, 0, 0);
    send(6'h23, 6'h00, 0, 32'h00001000, 32'h0, 16'hFFFC); expect_out("lw_addr", 32'h00000FFC, 0, 0);
    send(6'h3F, 6'h00, 0, 32'd5, 32'd5, 16'h0001);  expect_out("bad_op", 32'h0, 0, 0);
    send(6'h00, 6'h3F, 0, 32'd5, 32'd5, 0);         expect_out("bad_fn", 32'h0, 0, 0);

    send(6'h05, 6'h00, 0, 32'd5, 32'd5, 16'hFFFF);  expect_out("bne", 32'hFFFFFFFC, 0, 0);
    send(6'h07, 6'h00, 0, 32'd1, 32'd0, 16'h0004);  expect_out("bgtz", 32'h00000010, 1, 0);
    send(6'h06, 6'h00, 0, 32'h80000000, 32'd0, 16'h0001); expect_out("blez", 32'h00000004, 1, 0);
    send(6'h04, 6'h00, 0, 32'd7, 32'd7, 16'h0002);  expect_out("beq", 32'h00000008, 1, 0);

    // MULT -3*5 with a MFLO held behind it
    send(6'h00, 6'h18, 0, 32'hFFFFFFFD, 32'd5, 0);
    opcode = 6'h00; funct = 6'h12; rs_val = '0; rt_val = '0; in_valid = 1'b1;
    stall_ok = 1;
    n = 1;
    while (n < 40) begin
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) stall_ok = 0;
      @(negedge clk);
      n++;
    end
    check("mult_latency", n, 33);
    check("mult_stall", stall_ok, 1);
    check("mult_result", result, 32'hFFFFFFF1);
    check("mult_hi", hi_q, 32'hFFFFFFFF);
    check("mult_lo", lo_q, 32'hFFFFFFF1);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("mflo_after_mult", 32'hFFFFFFF1, 0, 0);

    send(6'h00, 6'h1A, 0, 32'hFFFFFFF9, 32'd2, 0);  expect_out("div", 32'hFFFFFFFD, 0, 0);
    check("div_hi", hi_q, 32'hFFFFFFFF);
    send(6'h00, 6'h10, 0, 0, 0, 0);                 expect_out("mfhi", 32'hFFFFFFFF, 0, 0);
    send(6'h00, 6'h1B, 0, 32'd9, 32'd0, 0);         expect_out("divu_zero", 32'hFFFFFFFF, 0, 0);
    check("divu_zero_hi", hi_q, 32'd9);
    send(6'h00, 6'h1A, 0, 32'h80000000, 32'hFFFFFFFF, 0); expect_out("div_minneg", 32'h80000000, 0, 0);
    check("div_minneg_hi", hi_q, 32'h0);
    send(6'h00, 6'h19, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0); expect_out("multu", 32'h00000001, 0, 0);
    check("multu_hi", hi_q, 32'hFFFFFFFE);

    // reset in the middle of MULT 7*6
    send(6'h00, 6'h18, 0, 32'd7, 32'd6, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_hi", hi_q, 0);
    check("rst_mid_lo", lo_q, 0);
    stall_ok = 1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) stall_ok = 0;
      @(negedge clk);
    end
    check("rst_mid_no_valid", stall_ok, 1);

    // back-to-back ADDI
    opcode = 6'h08; funct = '0; rs_val = 32'd10; immediate = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    check("b2b_1_valid", out_valid, 1);
    check("b2b_1", result, 32'd11);
    rs_val = 32'd20; immediate = 16'hFFFF;
    @(negedge clk);
    check("b2b_2_valid", out_valid, 1);
    check("b2b_2", result, 32'd19);
    rs_val = 32'h7FFFFFFF; immediate = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_3_valid", out_valid, 1);
    check("b2b_3", result, 32'h80000000);
    check("b2b_3_ov", overflow, 1);
    @(negedge clk);
    check("b2b_idle", out_valid, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
- Registered, parametrised successor to the combinational MIPS ALU in the execute stage.
- Adds signed overflow detection, unsigned compares, shifts, LUI and branch compares.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- Valid/ready handshake: multi-cycle MULT/DIV stalls issue; single-cycle ops return with fixed 1-cycle latency.

Parameters:
- WIDTH, 32: datapath width. Must be even and ≥ 8.
- IMM_W, 16: immediate field width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  ALU accepts an operation this cycle
- opcode  in  6  MIPS opcode field
- funct  in  6  MIPS funct field (R-type)
- shamt  in  5  shift amount field
- rs_val  in  WIDTH  rs operand
- rt_val  in  WIDTH  rt operand
- immediate  in  IMM_W  immediate field
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  ALU result
- branch_taken  out  1  branch condition true (qualified by out_valid)
- overflow  out  1  signed overflow on ADD/SUB/ADDI (qualified by out_valid)
- hi_q, lo_q  out  WIDTH each  current HI/LO register contents

Behaviour:
- Reset (synchronous, active-high, on a clk edge):
  - out_valid=0, result=0, branch_taken=0, overflow=0, hi_q=0, lo_q=0, in_ready=1.
  - Any in-flight mult/div is aborted, and its result is discarded.
- Handshake:
  - An operation is accepted when in_valid && in_ready.
  - in_ready = !busy; it is deasserted combinationally from the cycle after a MULT/DIV is accepted until out_valid for that op.
- Single-cycle ops: out_valid, result and flags are registered exactly 1 cycle after acceptance. Ops:
  - R-type: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, MFHI, MFLO.
  - I-type: ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, loads/stores (LB LH LW SB SH SW), BEQ, BNE, BLEZ, BGTZ.
- Arithmetic rules:
  - Sign-extend the immediate for ADDI/ADDIU/SLTI/SLTIU/loads/stores; zero-extend it for ANDI/ORI/XORI.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 0 or 1, zero-extended to WIDTH.
  - Variable shifts use rs_val[log2(WIDTH)-1:0]. SRA/SRAV replicate the sign bit.
  - LUI: result = immediate << (WIDTH-IMM_W); low bits are 0.
  - overflow=1 only for ADD/SUB/ADDI on signed overflow; the result is still written. Unsigned variants never flag.
- Branches:
  - result = sign-extended immediate << 2.
  - branch_taken set as follows: BEQ when rs==rt; BNE when rs!=rt; BLEZ when signed rs<=0; BGTZ when signed rs>0.
  - branch_taken=0 for all non-branch ops.
- MULT/MULTU/DIV/DIVU (sub-module): after acceptance, busy for WIDTH cycles (shift-add / restoring division).
  - out_valid on cycle WIDTH+1 after acceptance, with result = new LO; hi_q/lo_q update on that same edge.
  - MULT: {HI,LO} = signed rs*rt.
  - DIV: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
  - Divide by zero: LO = all ones, HI = rs_val, no exception.
  - DIV of most-negative by -1: LO = most-negative, HI = 0.
- MFHI/MFLO read the registered HI/LO. Since issue stalls while busy, they always see the completed value.
- Unknown opcode/funct: accepted; out_valid=1, result=0, flags=0.
- Back-to-back single-cycle ops: one per cycle. out_valid stays high on consecutive cycles.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams (OP_RTYPE, OP_ADDI, FN_ADD, FN_MULT, ...);
  - an op-class enum (ALU, SHIFT, BRANCH, MULDIV, MOVE).
- Sub-module mips_muldiv_iter, parameter WIDTH:
  - inputs: start, is_div, is_signed, a, b;
  - outputs: busy, done, hi, lo;
  - contains the iteration counter and the shift/accumulate registers.

Test Plan:
- Reset mid-MULT: issue MULT 7*6; assert reset at cycle 5 → in_ready=1 next cycle, hi_q=lo_q=0, no out_valid.
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, one cycle later. ADDU with the same operands → overflow=0.
- SLT vs SLTU with rs=0xFFFFFFFF, rt=1 → SLT gives 1, SLTU gives 0. SRA 0x80000000 by 4 → 0xF8000000.
- MULT -3*5 → out_valid at cycle 33, hi_q=0xFFFFFFFF, lo_q=0xFFFFFFF1. in_ready=0 throughout; a MFLO held on in_valid is accepted only afterwards and returns 0xFFFFFFF1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- BNE rs=rt=5, imm=0xFFFF → branch_taken=0, result 0xFFFFFFFC. BGTZ rs=1 → branch_taken=1. Back-to-back ADDI ops → out_valid high on consecutive cycles.
